sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'hACD51302, system ID value the block expects at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 32'h565D76CA, build timestamp the block expects at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, range 2..65535, maximum cycles allowed per read transaction.
REQ-004 Port: clock  in  1  single clock for all logic.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  level, sampled each cycle; starts a check sequence when high in IDLE.
REQ-007 Port: busy  out  1  high from the cycle after start is accepted until DONE is entered.
REQ-008 Port: done  out  1  one-cycle pulse when a sequence ends.
REQ-009 Port: id_ok, ts_ok  out  1 each  compare results of the last sequence.
REQ-010 Port: timeout  out  1  last sequence aborted by timeout.
REQ-011 Port: id_value, ts_value  out  32 each  captured read data.
REQ-012 Port: avm_address  out  1  Avalon-MM word address; 0 = ID, 1 = timestamp.
REQ-013 Port: avm_read  out  1  Avalon-MM read request.
REQ-014 Port: avm_waitrequest  in  1  slave stall.
REQ-015 Port: avm_readdata  in  32  read data.
REQ-016 Port: avm_readdatavalid  in  1  read data qualifier, latency >= 0 cycles after command acceptance.

Function
REQ-017 FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
REQ-018 IDLE -> RD_ID when start=1; start ignored in all other states.
REQ-019 RD_ID / RD_TS: avm_read=1, avm_address=0 / 1; command accepted in the cycle avm_waitrequest=0; avm_read and avm_address held stable until acceptance.
REQ-020 On acceptance: if avm_readdatavalid=1 in the same cycle, data captured and next read state (or DONE) entered; otherwise WT_ID / WT_TS entered.
REQ-021 WT_ID / WT_TS: avm_read=0; on avm_readdatavalid=1, avm_readdata captured into id_value / ts_value; WT_ID -> RD_TS, WT_TS -> DONE.
REQ-022 id_ok = (id_value == EXPECTED_ID) and ts_ok = (ts_value == EXPECTED_TS), both registered at DONE entry; exact 32-bit compare.
REQ-023 DONE lasts exactly one cycle with done=1, then -> IDLE; status outputs held until the next accepted start, which clears them.
REQ-024 Nominal latency with zero-wait, zero-latency slave: start accepted cycle N, done=1 in cycle N+3.
REQ-025 avm_readdatavalid outside WT_x or same-cycle acceptance ignored.

Reset
REQ-026 reset_n=0 at a rising edge: state=IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, timeout counter=0.
REQ-027 Reset mid-sequence aborts immediately; avm_read low on the first cycle after reset; no done pulse.

Configuration
REQ-028 Macro SYSID_CHECKER_TIMEOUT_EN: when defined, 16-bit counter clears on entry to each RD_x and increments in RD_x/WT_x; on reaching TIMEOUT_CYCLES, avm_read dropped, timeout=1, id_ok/ts_ok forced 0, -> DONE.
REQ-029 Without SYSID_CHECKER_TIMEOUT_EN: no counter, timeout tied 0, FSM waits indefinitely.

Structure
REQ-030 Package sysid_checker_pkg holds the state enum and default EXPECTED_ID/EXPECTED_TS/TIMEOUT_CYCLES constants.
REQ-031 Single module, no sub-modules; timeout counter inline.

Verification
REQ-032 Zero-wait slave returning 0xACD51302 / 0x565D76CA: start pulse cycle 0 -> done cycle 3, id_ok=1, ts_ok=1, timeout=0.
REQ-033 Slave returns ID 0x00000001 -> id_ok=0, ts_ok=1, id_value=0x00000001.
REQ-034 waitrequest high 5 cycles, readdatavalid 2 cycles after acceptance -> avm_read/avm_address stable during stall, correct capture, done once.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts readdatavalid -> done 8 cycles after RD_ID entry, timeout=1, avm_read=0.
REQ-036 start held high throughout and reset_n pulsed low during WT_TS -> no done, all outputs reset values, new sequence begins in the cycle after reset release.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared types and default constants for the system ID / build timestamp checker.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_WT_ID = 3'd2,
        ST_RD_TS = 3'd3,
        ST_WT_TS = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'hACD51302;
    localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'h565D76CA;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/sysid_checker.sv
// Reads slave words 0 (system ID) and 1 (build timestamp) over Avalon-MM and compares them
// with the expected values. Define SYSID_CHECKER_TIMEOUT_EN to bound each read by TIMEOUT_CYCLES.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    state_e      state_r;
    logic        busy_r;
    logic        done_r;
    logic        id_ok_r;
    logic        ts_ok_r;
    logic        timeout_r;
    logic        avm_read_r;
    logic        avm_address_r;
    logic [31:0] id_value_r;
    logic [31:0] ts_value_r;

    logic        accept_s;
    logic        id_hit_s;
    logic        ts_hit_s;
    logic        timeout_hit_s;

    // Decode command acceptance and data capture for the current read phase
    always_comb begin
        accept_s = 1'b0;
        id_hit_s = 1'b0;
        ts_hit_s = 1'b0;
        case (state_r)
            ST_RD_ID: begin
                accept_s = ~avm_waitrequest;
                id_hit_s = ~avm_waitrequest & avm_readdatavalid;
            end
            ST_WT_ID: id_hit_s = avm_readdatavalid;
            ST_RD_TS: begin
                accept_s = ~avm_waitrequest;
                ts_hit_s = ~avm_waitrequest & avm_readdatavalid;
            end
            ST_WT_TS: ts_hit_s = avm_readdatavalid;
            default: begin
                accept_s = 1'b0;
                id_hit_s = 1'b0;
                ts_hit_s = 1'b0;
            end
        endcase
    end

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_r;
    logic        cnt_clear_s;
    logic        cnt_run_s;

    // Counter restarts on entry to each read state and runs while a read is outstanding
    always_comb begin
        cnt_clear_s = (state_r == ST_IDLE && start) || id_hit_s;
        cnt_run_s   = (state_r == ST_RD_ID) || (state_r == ST_WT_ID) ||
                      (state_r == ST_RD_TS) || (state_r == ST_WT_TS);
    end

    assign timeout_hit_s = cnt_run_s && (tmo_cnt_r == TIMEOUT_LAST);

    // Per-transaction cycle counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tmo_cnt_r <= 16'd0;
        end else if (cnt_clear_s) begin
            tmo_cnt_r <= 16'd0;
        end else if (cnt_run_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Main sequencer; all outputs are registered here. Completed data beats a same-cycle timeout.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            id_ok_r       <= 1'b0;
            ts_ok_r       <= 1'b0;
            timeout_r     <= 1'b0;
            avm_read_r    <= 1'b0;
            avm_address_r <= 1'b0;
            id_value_r    <= 32'd0;
            ts_value_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r       <= ST_RD_ID;
                        busy_r        <= 1'b1;
                        avm_read_r    <= 1'b1;
                        avm_address_r <= 1'b0;
                        id_ok_r       <= 1'b0;
                        ts_ok_r       <= 1'b0;
                        timeout_r     <= 1'b0;
                        id_value_r    <= 32'd0;
                        ts_value_r    <= 32'd0;
                    end
                end
                ST_RD_ID, ST_WT_ID: begin
                    if (id_hit_s) begin
                        state_r       <= ST_RD_TS;
                        id_value_r    <= avm_readdata;
                        avm_read_r    <= 1'b1;
                        avm_address_r <= 1'b1;
                    end else if (timeout_hit_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        avm_read_r <= 1'b0;
                        timeout_r  <= 1'b1;
                        id_ok_r    <= 1'b0;
                        ts_ok_r    <= 1'b0;
                    end else if (accept_s) begin
                        state_r    <= ST_WT_ID;
                        avm_read_r <= 1'b0;
                    end
                end
                ST_RD_TS, ST_WT_TS: begin
                    if (ts_hit_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        avm_read_r <= 1'b0;
                        ts_value_r <= avm_readdata;
                        id_ok_r    <= (id_value_r == EXPECTED_ID);
                        ts_ok_r    <= (avm_readdata == EXPECTED_TS);
                    end else if (timeout_hit_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        avm_read_r <= 1'b0;
                        timeout_r  <= 1'b1;
                        id_ok_r    <= 1'b0;
                        ts_ok_r    <= 1'b0;
                    end else if (accept_s) begin
                        state_r    <= ST_WT_TS;
                        avm_read_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    avm_read_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign timeout     = timeout_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;
    assign avm_read    = avm_read_r;
    assign avm_address = avm_address_r;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: randomized Avalon slave, expected results queued at start.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hACD51302;
    localparam logic [31:0] EXP_TS = 32'h565D76CA;
    localparam int          TMO    = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy, done, id_ok, ts_ok, timeout, avm_address, avm_read;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout), .id_value(id_value),
        .ts_value(ts_value), .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
    } exp_t;
    exp_t sb_q[$];

    // Slave behaviour knobs
    logic [31:0] slv_id_data = 32'd0;
    logic [31:0] slv_ts_data = 32'd0;
    int          force_stall = -1;
    int          force_lat = -1;
    int          max_stall = 5;
    int          max_lat = 3;
    bit          slv_mute = 1'b0;
    bit          pending = 1'b0;
    bit          cmd_active = 1'b0;
    int          stall_left = 0;
    int          lat_left = 0;
    int          cur_lat = 0;
    logic [31:0] pend_data = 32'd0;
    logic [31:0] cur_data = 32'd0;

    // Avalon slave: random stall and latency, stray readdatavalid when no read is owed
    initial begin
        forever begin
            @(negedge clock);
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom();
            if (pending) begin
                if (lat_left == 0) begin
                    pending = 1'b0;
                    if (!slv_mute) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end else begin
                    lat_left = lat_left - 1;
                end
            end else if (avm_read === 1'b1) begin
                if (!cmd_active) begin
                    cmd_active = 1'b1;
                    stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(max_stall, 0));
                end
                cur_data = (avm_address === 1'b1) ? slv_ts_data : slv_id_data;
                if (stall_left > 0) begin
                    avm_waitrequest   = 1'b1;
                    stall_left        = stall_left - 1;
                    avm_readdatavalid = ($urandom_range(3, 0) == 0);
                end else begin
                    cmd_active = 1'b0;
                    cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(max_lat, 0));
                    if (cur_lat == 0) begin
                        if (!slv_mute) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = cur_data;
                        end
                    end else begin
                        pending   = 1'b1;
                        lat_left  = cur_lat - 1;
                        pend_data = cur_data;
                    end
                end
            end else begin
                avm_readdatavalid = !slv_mute && ($urandom_range(7, 0) == 0);
            end
        end
    end

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        bit prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (prev_done) check("done_width", 32'd2, 32'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("id_value", id_value, e.id_v);
                    check("ts_value", ts_value, e.ts_v);
                    check("id_ok", {31'd0, id_ok}, {31'd0, e.id_ok});
                    check("ts_ok", {31'd0, ts_ok}, {31'd0, e.ts_ok});
                    check("timeout", {31'd0, timeout}, {31'd0, e.tmo});
                    check("done_read_low", {31'd0, avm_read}, 32'd0);
                    check("done_busy_low", {31'd0, busy}, 32'd0);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    // Stall monitor: read command must stay stable while waitrequest is high
    initial begin
        bit   stall_prev;
        logic stall_addr;
        stall_prev = 1'b0;
        stall_addr = 1'b0;
        forever begin
            @(posedge clock);
            if (reset_n === 1'b1) begin
                if (stall_prev) begin
                    check("stall_read", {31'd0, avm_read}, 32'd1);
                    check("stall_addr", {31'd0, avm_address}, {31'd0, stall_addr});
                end
                stall_prev = (avm_read === 1'b1) && (avm_waitrequest === 1'b1);
                stall_addr = avm_address;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
        check({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
        check({tag, "_id_ok"}, {31'd0, id_ok}, 32'd0);
        check({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_id_value"}, id_value, 32'd0);
        check({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("idle_bound", 32'd1, 32'd0);
    endtask

    function automatic exp_t model(input logic [31:0] id_d, input logic [31:0] ts_d, input bit tmo);
        exp_t e;
        e.id_v  = tmo ? 32'd0 : id_d;
        e.ts_v  = tmo ? 32'd0 : ts_d;
        e.id_ok = !tmo && (id_d == EXP_ID);
        e.ts_ok = !tmo && (ts_d == EXP_TS);
        e.tmo   = tmo;
        return e;
    endfunction

    // Issue one start pulse and return the number of cycles until done appears
    task automatic run_seq(input logic [31:0] id_d, input logic [31:0] ts_d, input bit tmo,
                           output int lat);
        wait_idle();
        slv_id_data = id_d;
        slv_ts_data = ts_d;
        sb_q.push_back(model(id_d, ts_d, tmo));
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 300) begin
            step();
            lat++;
        end
        if (lat >= 300) check("done_bound", 32'd1, 32'd0);
    endtask

    initial begin
        int          lat;
        int          n;
        logic [31:0] one;
        logic [31:0] id_d;
        logic [31:0] ts_d;
        one = 32'd1;

        repeat (3) step();
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Zero-wait slave, expected values
        force_stall = 0;
        force_lat = 0;
        run_seq(EXP_ID, EXP_TS, 1'b0, lat);
        check("lat_zero_wait", lat, 32'd3);

        // Wrong ID
        run_seq(32'h00000001, EXP_TS, 1'b0, lat);
        check("lat_bad_id", lat, 32'd3);

        // Five stall cycles, data two cycles after acceptance
        force_stall = 5;
        force_lat = 2;
        run_seq(EXP_ID, EXP_TS, 1'b0, lat);
        check("lat_stall", lat, 1 + 2 * (5 + 2 + 1));

        // Random slave timing and data
        force_stall = -1;
        force_lat = -1;
`ifdef SYSID_CHECKER_TIMEOUT_EN
        max_stall = 3;
        max_lat = 3;
`endif
        for (int t = 0; t < 24; t++) begin
            id_d = EXP_ID;
            ts_d = EXP_TS;
            case ($urandom_range(3, 0))
                0: ;
                1: begin id_d = $urandom(); ts_d = $urandom(); end
                2: id_d = EXP_ID ^ (one << $urandom_range(31, 0));
                default: ts_d = EXP_TS ^ (one << $urandom_range(31, 0));
            endcase
            run_seq(id_d, ts_d, 1'b0, lat);
        end

        // Reset while waiting for timestamp data, start held high throughout
        wait_idle();
        force_stall = 0;
        force_lat = 4;
        slv_id_data = EXP_ID;
        slv_ts_data = EXP_TS;
        sb_q.push_back(model(EXP_ID, EXP_TS, 1'b0));
        start = 1'b1;
        n = 0;
        step();
        while (!(avm_address === 1'b1 && avm_read === 1'b0 && busy === 1'b1) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("wt_ts_bound", 32'd1, 32'd0);
        reset_n = 1'b0;
        step();
        sb_q.delete();
        check_reset_vals("midreset");
        pending = 1'b0;
        cmd_active = 1'b0;
        reset_n = 1'b1;
        sb_q.push_back(model(EXP_ID, EXP_TS, 1'b0));
        step();
        check("restart_read", {31'd0, avm_read}, 32'd1);
        check("restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_idle();

`ifdef SYSID_CHECKER_TIMEOUT_EN
        // Slave accepts but never returns data
        force_stall = 0;
        force_lat = 0;
        slv_mute = 1'b1;
        run_seq(EXP_ID, EXP_TS, 1'b1, lat);
        check("lat_timeout", lat, TMO + 1);
        slv_mute = 1'b0;
`endif

        repeat (4) step();
        check("sb_drain", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
